// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_if
//  Description : Bus and pipeline handshake bundle for the interrupt
//                controller.
//                Data-memory bus : Address, Write_data, MemWrite, MemRead -> Read_data
//                Pipeline        : kernel, take_ack, pc_in, eret -> int_req, int_cause, epc
//                master = CPU / pipeline side, slave = interrupt controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface int_ctrl_if;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;
    logic        kernel;
    logic        take_ack;
    logic [31:0] pc_in;
    logic        eret;
    logic        int_req;
    logic [1:0]  int_cause;
    logic [31:0] epc;

    modport master (
        output Address, Write_data, MemWrite, MemRead,
        output kernel, take_ack, pc_in, eret,
        input  Read_data, int_req, int_cause, epc
    );

    modport slave (
        input  Address, Write_data, MemWrite, MemRead,
        input  kernel, take_ack, pc_in, eret,
        output Read_data, int_req, int_cause, epc
    );
endinterface
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Four-source interrupt controller. Rising edges on the level
//                lines set IPEND; IPEND & IMASK selects the lowest-index
//                source. A REQ/ack handshake with the PC-select logic saves
//                the resume PC in EPC; no new request until eret.
//  Ports       : clk      - system clock
//                reset    - synchronous active-high reset
//                irq_src  - level interrupt lines (bit 0 = timer, top priority)
//                bus      - int_ctrl_if.slave (register bus + pipeline handshake)
//  Registers   : BASE+0 IPEND (W1C), BASE+4 IMASK, BASE+8 ICAUSE (RO),
//                BASE+12 EPC (RO)
//  Revision    : 1.0  initial release
// ============================================================================
module int_ctrl #(
    parameter int          N_SRC = 4,
    parameter logic [31:0] BASE  = 32'h40000018
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [N_SRC-1:0] irq_src,
    int_ctrl_if.slave             bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [N_SRC-1:0]   ipend_q,   ipend_d;
    logic [N_SRC-1:0]   imask_q,   imask_d;
    logic [N_SRC-1:0]   src_dly_q;
    logic [31:0]        epc_q,     epc_d;
    logic [1:0]         cause_q,   cause_d;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   w1c;
    logic [N_SRC-1:0]   ack_clr;
    logic [N_SRC-1:0]   active;
    logic [N_SRC-1:0]   active_nxt;
    logic [1:0]         winner;
    logic               hit_pend, hit_mask, hit_cause, hit_epc;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Address decode (full 32-bit compare, word registers)
    // ------------------------------------------------------------------
    assign hit_pend  = (bus.Address == BASE);
    assign hit_mask  = (bus.Address == BASE + 32'd4);
    assign hit_cause = (bus.Address == BASE + 32'd8);
    assign hit_epc   = (bus.Address == BASE + 32'd12);

    assign w_unused  = ^bus.Write_data[31:N_SRC];

    // ------------------------------------------------------------------
    // Edge capture, pending and mask next-state
    // ------------------------------------------------------------------
    assign rise = irq_src & ~src_dly_q;
    assign w1c  = (bus.MemWrite && hit_pend) ? bus.Write_data[N_SRC-1:0] : '0;

    always_comb begin
        imask_d = imask_q;
        if (bus.MemWrite && hit_mask) begin
            imask_d = bus.Write_data[N_SRC-1:0];
        end
    end

    // A rising edge is OR-ed in last so it wins over both W1C and the
    // acknowledge clear of the same bit.
    assign ipend_d = (ipend_q & ~w1c & ~ack_clr) | rise;

    assign active = ipend_q & imask_q;

    // Selection as it will stand after this edge's bus writes; used to
    // withdraw a request in the same edge that masks or clears its bit.
    assign active_nxt = ((ipend_q & ~w1c) | rise) & imask_d;

    // Lowest-index active source wins.
    always_comb begin
        winner = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                winner = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request / service state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        ack_clr = '0;
        case (state_q)
            ST_IDLE: begin
                if ((|active) && !bus.kernel) begin
                    state_d = ST_REQ;
                    cause_d = winner;
                end
            end
            ST_REQ: begin
                if (bus.take_ack) begin
                    state_d          = ST_SERVICE;
                    epc_d            = bus.pc_in;
                    ack_clr[cause_q] = 1'b1;
                end else if (bus.kernel || !active_nxt[cause_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ipend_q   <= '0;
            imask_q   <= '0;
            src_dly_q <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            ipend_q   <= ipend_d;
            imask_q   <= imask_d;
            src_dly_q <= irq_src;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.int_req   = (state_q == ST_REQ);
    assign bus.int_cause = cause_q;
    assign bus.epc       = epc_q;

    always_comb begin
        bus.Read_data = 32'd0;
        if (bus.MemRead) begin
            if (hit_pend) begin
                bus.Read_data = {{(32-N_SRC){1'b0}}, ipend_q};
            end else if (hit_mask) begin
                bus.Read_data = {{(32-N_SRC){1'b0}}, imask_q};
            end else if (hit_cause) begin
                bus.Read_data = {30'd0, cause_q};
            end else if (hit_epc) begin
                bus.Read_data = epc_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Self-checking bench for int_ctrl. A behavioural model tracks
//                pending/mask/handler status; a negedge process compares the
//                DUT with it every cycle. Directed scenarios add literal
//                expectations, followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_ctrl;

    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] A_PEND  = BASE;
    localparam logic [31:0] A_MASK  = BASE + 32'd4;
    localparam logic [31:0] A_CAUSE = BASE + 32'd8;
    localparam logic [31:0] A_EPC   = BASE + 32'd12;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] irq_src = 4'd0;

    int_ctrl_if bus_if ();

    int_ctrl #(
        .N_SRC (4),
        .BASE  (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [3:0]  m_prev = '0;
    logic [3:0]  m_pend = '0;
    logic [3:0]  m_mask = '0;
    logic [1:0]  m_cause = '0;
    logic [31:0] m_epc = '0;
    bit          m_requesting = 1'b0;
    bit          m_in_handler = 1'b0;

    function automatic logic [1:0] lowest(input logic [3:0] a);
        bit found = 1'b0;
        lowest = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] && !found) begin
                lowest = 2'(i);
                found  = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic rd, input logic [31:0] a);
        exp_read = 32'd0;
        if (rd) begin
            if (a == A_PEND)       exp_read = {28'd0, m_pend};
            else if (a == A_MASK)  exp_read = {28'd0, m_mask};
            else if (a == A_CAUSE) exp_read = {30'd0, m_cause};
            else if (a == A_EPC)   exp_read = m_epc;
        end
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] rise, w1c, old_active, new_pend, new_mask;
        if (reset) begin
            m_prev = '0; m_pend = '0; m_mask = '0; m_cause = '0; m_epc = '0;
            m_requesting = 1'b0; m_in_handler = 1'b0;
        end else begin
            rise       = irq_src & ~m_prev;
            m_prev     = irq_src;
            w1c        = (bus_if.MemWrite && bus_if.Address == A_PEND) ? bus_if.Write_data[3:0] : 4'd0;
            new_mask   = (bus_if.MemWrite && bus_if.Address == A_MASK) ? bus_if.Write_data[3:0] : m_mask;
            old_active = m_pend & m_mask;
            new_pend   = (m_pend & ~w1c) | rise;
            if (m_in_handler) begin
                if (bus_if.eret) m_in_handler = 1'b0;
            end else if (m_requesting) begin
                if (bus_if.take_ack) begin
                    m_requesting = 1'b0;
                    m_in_handler = 1'b1;
                    m_epc        = bus_if.pc_in;
                    // serviced source is cleared unless a fresh edge re-arms it
                    new_pend[m_cause] = rise[m_cause];
                end else if (bus_if.kernel || !(new_pend[m_cause] && new_mask[m_cause])) begin
                    m_requesting = 1'b0;
                end
            end else if (old_active != 4'd0 && !bus_if.kernel) begin
                m_requesting = 1'b1;
                m_cause      = lowest(old_active);
            end
            m_pend = new_pend;
            m_mask = new_mask;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("int_req",   {31'd0, bus_if.int_req}, {31'd0, m_requesting});
            check("int_cause", {30'd0, bus_if.int_cause}, {30'd0, m_cause});
            check("epc",       bus_if.epc, m_epc);
            check("Read_data", bus_if.Read_data, exp_read(bus_if.MemRead, bus_if.Address));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.MemWrite   = 1'b1;
        bus_if.Address    = a;
        bus_if.Write_data = d;
        tick();
        bus_if.MemWrite   = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_if.MemRead = 1'b1;
        bus_if.Address = a;
        #1;
        d = bus_if.Read_data;
        bus_if.MemRead = 1'b0;
        check(name, d, exp);
    endtask

    task automatic ack(input logic [31:0] pc);
        bus_if.take_ack = 1'b1;
        bus_if.pc_in    = pc;
        tick();
        bus_if.take_ack = 1'b0;
    endtask

    task automatic do_eret();
        bus_if.eret = 1'b1;
        tick();
        bus_if.eret = 1'b0;
    endtask

    int nreq;

    initial begin
        bus_if.Address    = 32'd0;
        bus_if.Write_data = 32'd0;
        bus_if.MemWrite   = 1'b0;
        bus_if.MemRead    = 1'b0;
        bus_if.kernel     = 1'b0;
        bus_if.take_ack   = 1'b0;
        bus_if.pc_in      = 32'd0;
        bus_if.eret       = 1'b0;

        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_int_req", {31'd0, bus_if.int_req}, 32'd0);
        rd_check("rst_IPEND", A_PEND, 32'd0);
        rd_check("rst_IMASK", A_MASK, 32'd0);
        rd_check("rst_EPC",   A_EPC,  32'd0);

        // Basic request: pulse src0, request two edges later
        bus_write(A_MASK, 32'h1);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        check("basic_req_early", {31'd0, bus_if.int_req}, 32'd0);
        tick();
        check("basic_req", {31'd0, bus_if.int_req}, 32'd1);
        ack(32'h00000124);
        check("basic_after_ack", {31'd0, bus_if.int_req}, 32'd0);
        rd_check("basic_EPC",    A_EPC,   32'h00000124);
        rd_check("basic_ICAUSE", A_CAUSE, 32'd0);
        rd_check("basic_IPEND",  A_PEND,  32'd0);
        repeat (5) tick();
        do_eret();
        check("basic_idle", {31'd0, bus_if.int_req}, 32'd0);

        // Priority: sources 3 and 1 together
        bus_write(A_MASK, 32'hF);
        irq_src = 4'b1010;
        tick();
        irq_src = 4'b0000;
        tick();
        check("prio_first", {30'd0, bus_if.int_cause}, 32'd1);
        ack(32'h00000300);
        do_eret();
        check("prio_gap", {31'd0, bus_if.int_req}, 32'd0);
        tick();
        check("prio_second_req", {31'd0, bus_if.int_req}, 32'd1);
        check("prio_second", {30'd0, bus_if.int_cause}, 32'd3);
        ack(32'h00000304);
        do_eret();

        // Masked source
        bus_write(A_MASK, 32'h0);
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        repeat (3) tick();
        check("masked_noreq", {31'd0, bus_if.int_req}, 32'd0);
        rd_check("masked_IPEND", A_PEND, 32'h4);
        bus_write(A_MASK, 32'h4);
        check("unmask_wait", {31'd0, bus_if.int_req}, 32'd0);
        tick();
        check("unmask_req", {31'd0, bus_if.int_req}, 32'd1);
        check("unmask_cause", {30'd0, bus_if.int_cause}, 32'd2);
        ack(32'h00000308);
        do_eret();

        // Level held high: one request only
        bus_write(A_MASK, 32'h1);
        bus_if.pc_in = 32'h00000400;
        irq_src[0] = 1'b1;
        nreq = 0;
        for (int i = 0; i < 50; i++) begin
            bus_if.take_ack = bus_if.int_req;
            if (bus_if.int_req) nreq++;
            bus_if.eret = (i == 20);
            tick();
        end
        bus_if.take_ack = 1'b0;
        bus_if.eret     = 1'b0;
        irq_src[0]      = 1'b0;
        check("level_once", nreq, 32'd1);

        // W1C collides with a rising edge on the same bit
        irq_src[1]        = 1'b1;
        bus_if.MemWrite   = 1'b1;
        bus_if.Address    = A_PEND;
        bus_if.Write_data = 32'h2;
        tick();
        bus_if.MemWrite   = 1'b0;
        rd_check("collide_IPEND", A_PEND, 32'h2);
        irq_src[1] = 1'b0;
        bus_write(A_PEND, 32'hF);
        rd_check("w1c_IPEND", A_PEND, 32'h0);

        // Kernel blocks; W1C in REQ withdraws
        bus_if.kernel = 1'b1;
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        repeat (5) tick();
        check("kernel_noreq", {31'd0, bus_if.int_req}, 32'd0);
        bus_if.kernel = 1'b0;
        tick();
        check("kernel_drop_req", {31'd0, bus_if.int_req}, 32'd1);
        bus_write(A_PEND, 32'h1);
        check("withdraw", {31'd0, bus_if.int_req}, 32'd0);
        rd_check("withdraw_EPC", A_EPC, 32'h00000400);

        // Reset in SERVICE
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick();
        ack(32'h00000500);
        check("svc_epc", bus_if.epc, 32'h00000500);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_check("rst2_IPEND",  A_PEND,  32'd0);
        rd_check("rst2_IMASK",  A_MASK,  32'd0);
        rd_check("rst2_ICAUSE", A_CAUSE, 32'd0);
        rd_check("rst2_EPC",    A_EPC,   32'd0);
        do_eret();
        check("rst2_int_req", {31'd0, bus_if.int_req}, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] a;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            end
            bus_if.kernel   = ($urandom_range(0, 9) == 0);
            bus_if.take_ack = bus_if.int_req ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 19) == 0);
            bus_if.pc_in    = $urandom;
            bus_if.eret     = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 5))
                0:       a = A_PEND;
                1:       a = A_MASK;
                2:       a = A_CAUSE;
                3:       a = A_EPC;
                4:       a = BASE + 32'd16;
                default: a = BASE + 32'd2;
            endcase
            bus_if.Address    = a;
            bus_if.Write_data = $urandom;
            bus_if.MemWrite   = ($urandom_range(0, 4) == 0);
            bus_if.MemRead    = ($urandom_range(0, 1) == 0);
            reset             = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset           = 1'b0;
        bus_if.MemWrite = 1'b0;
        bus_if.MemRead  = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
